button_debouncer: RTL

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// Button debouncer: 2-flop synchronizer, stability-counted press/release
// acceptance, and a one-shot long-press pulse.
module button_debouncer #(
  parameter int STABLE_CYCLES = 16,
  parameter int LONG_CYCLES   = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_clean,
  output logic btn_release,
  output logic btn_long,
  output logic btn_level
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int LW = $clog2(LONG_CYCLES + 1);

  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] HOLD_SAT  = LW'(LONG_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_sync1;
  logic          r_sync2;
  logic [SW-1:0] r_stab;
  logic [SW-1:0] w_stab_nxt;
  logic [LW-1:0] r_hold;
  logic [LW-1:0] w_hold_nxt;
  logic          r_clean;
  logic          r_release;
  logic          r_long;
  logic          r_level;
  logic          w_clean_nxt;
  logic          w_release_nxt;
  logic          w_long_nxt;
  logic          w_level_nxt;
  logic          w_s;

  assign w_s = r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_stab    <= '0;
      r_hold    <= '0;
      r_clean   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_level   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_stab    <= w_stab_nxt;
      r_hold    <= w_hold_nxt;
      r_clean   <= w_clean_nxt;
      r_release <= w_release_nxt;
      r_long    <= w_long_nxt;
      r_level   <= w_level_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_stab_nxt    = r_stab;
    w_hold_nxt    = r_hold;
    w_clean_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;
    w_level_nxt   = r_level;
    unique case (r_state)
      IDLE: begin
        if (w_s) begin
          w_state_nxt = PRESS_WAIT;
          w_stab_nxt  = SW'(1);
        end else begin
          w_stab_nxt  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_s) begin
          w_state_nxt = IDLE;
          w_stab_nxt  = '0;
        end else if (r_stab == STAB_LAST) begin
          w_state_nxt = PRESSED;
          w_stab_nxt  = '0;
          w_hold_nxt  = '0;
          w_clean_nxt = 1'b1;
          w_level_nxt = 1'b1;
        end else begin
          w_stab_nxt  = r_stab + SW'(1);
        end
      end
      PRESSED: begin
        // A low sample freezes the hold count until the release settles
        if (!w_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_stab_nxt  = SW'(1);
        end else if (r_hold != HOLD_SAT) begin
          w_hold_nxt  = r_hold + LW'(1);
          w_long_nxt  = (r_hold == HOLD_LAST);
        end
      end
      RELEASE_WAIT: begin
        if (w_s) begin
          w_state_nxt = PRESSED;
          w_stab_nxt  = '0;
        end else if (r_stab == STAB_LAST) begin
          w_state_nxt   = IDLE;
          w_stab_nxt    = '0;
          w_hold_nxt    = '0;
          w_release_nxt = 1'b1;
          w_level_nxt   = 1'b0;
        end else begin
          w_stab_nxt    = r_stab + SW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_stab_nxt  = '0;
        w_hold_nxt  = '0;
        w_level_nxt = 1'b0;
      end
    endcase
  end

  assign btn_clean   = r_clean;
  assign btn_release = r_release;
  assign btn_long    = r_long;
  assign btn_level   = r_level;

endmodule
